// File: rtl/uart_num_formatter.sv
// Formats a 32-bit value as "<tag>=<decimal>" and hands it to the UART string transmitter.
// Define NUM_FMT_SIGNED_EN to treat fmt_value as two's complement with a leading '-'.
module uart_num_formatter #(
  parameter logic [7:0] SEP_CHAR      = 8'h3D,
  parameter int         BUSY_WAIT_MAX = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          fmt_req,
  input  logic [31:0]   fmt_value,
  input  logic [7:0]    fmt_tag,
  output logic          fmt_ready,
  output logic          fmt_done,
  output logic          fmt_err,
  output logic [1095:0] tx_string,
  output logic [7:0]    tx_length,
  output logic          tx_req,
  input  logic          tx_busy
);

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    PACK,
    SEND,
    WAIT_BUSY,
    WAIT_IDLE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   bin_reg;
  logic [39:0]   bcd_reg;
  logic [39:0]   bcd_adj;
  logic [4:0]    step_cnt;
  logic [7:0]    wait_cnt;
  logic [103:0]  payload;
  logic          started;
  logic [3:0]    digit_idx;
  logic [3:0]    digit;
  logic          emit;

  // Payload never exceeds 13 bytes, so only the low bytes are real storage.
  assign tx_string = {992'b0, payload};
  assign fmt_ready = (state == IDLE);

  always_comb begin
    bcd_adj = bcd_reg;
    for (int i = 0; i < 10; i++) begin
      if (bcd_reg[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
      end
    end
  end

  // PACK walks digits MSD first; the units digit always emits so zero prints as "0".
  assign digit_idx = 4'd9 - step_cnt[3:0];
  assign digit     = bcd_reg[{digit_idx, 2'b00} +: 4];
  assign emit      = started | (digit != 4'd0) | (digit_idx == 4'd0);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (fmt_req) state_nxt = CONV;
      CONV:      if (step_cnt == 5'd31) state_nxt = PACK;
      PACK:      if (step_cnt == 5'd9) state_nxt = SEND;
      SEND:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_IDLE;
        end else if (wait_cnt == 8'(BUSY_WAIT_MAX - 1)) begin
          state_nxt = IDLE;
        end
      end
      WAIT_IDLE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      bin_reg   <= '0;
      bcd_reg   <= '0;
      step_cnt  <= '0;
      wait_cnt  <= '0;
      payload   <= '0;
      started   <= 1'b0;
      tx_length <= '0;
      tx_req    <= 1'b0;
      fmt_done  <= 1'b0;
      fmt_err   <= 1'b0;
    end else begin
      tx_req   <= 1'b0;
      fmt_done <= 1'b0;
      fmt_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (fmt_req) begin
            bin_reg   <= fmt_value;
            bcd_reg   <= '0;
            step_cnt  <= '0;
            wait_cnt  <= '0;
            started   <= 1'b0;
            payload   <= {88'h0, SEP_CHAR, fmt_tag};
            tx_length <= 8'd2;
`ifdef NUM_FMT_SIGNED_EN
            if (fmt_value[31]) begin
              bin_reg        <= 32'(-fmt_value);
              payload[23:16] <= 8'h2D;
              tx_length      <= 8'd3;
            end
`endif
          end
        end
        CONV: begin
          {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
          step_cnt           <= step_cnt + 5'd1;
        end
        PACK: begin
          if (emit) begin
            payload[{tx_length[3:0], 3'b000} +: 8] <= 8'h30 + {4'h0, digit};
            tx_length <= tx_length + 8'd1;
            started   <= 1'b1;
          end
          step_cnt <= step_cnt + 5'd1;
        end
        SEND: begin
          tx_req   <= 1'b1;
          wait_cnt <= '0;
        end
        WAIT_BUSY: begin
          if (!tx_busy) begin
            if (wait_cnt == 8'(BUSY_WAIT_MAX - 1)) begin
              fmt_err <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
        end
        WAIT_IDLE: begin
          if (!tx_busy) fmt_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_num_formatter.sv
// Directed bench for uart_num_formatter; signed cases run when NUM_FMT_SIGNED_EN is defined.
module tb_uart_num_formatter;

  logic          sys_clk;
  logic          sys_rst_n;
  logic          fmt_req;
  logic [31:0]   fmt_value;
  logic [7:0]    fmt_tag;
  logic          fmt_ready;
  logic          fmt_done;
  logic          fmt_err;
  logic [1095:0] tx_string;
  logic [7:0]    tx_length;
  logic          tx_req;
  logic          tx_busy;

  int assertCount = 0;
  int failCount   = 0;

  uart_num_formatter dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .fmt_req   (fmt_req),
    .fmt_value (fmt_value),
    .fmt_tag   (fmt_tag),
    .fmt_ready (fmt_ready),
    .fmt_done  (fmt_done),
    .fmt_err   (fmt_err),
    .tx_string (tx_string),
    .tx_length (tx_length),
    .tx_req    (tx_req),
    .tx_busy   (tx_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic stepCycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [103:0] observed,
                             input logic [103:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [103:0] makePayload(input logic [7:0] tag, input string digits);
    logic [103:0] p;
    p        = '0;
    p[7:0]   = tag;
    p[15:8]  = 8'h3D;
    for (int i = 0; i < digits.len(); i++) p[8*(i+2) +: 8] = digits[i];
    return p;
  endfunction

  // Pulses fmt_req for one edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] value, input logic [7:0] tag);
    fmt_value = value;
    fmt_tag   = tag;
    fmt_req   = 1'b1;
    stepCycle();
    fmt_req   = 1'b0;
  endtask

  task automatic waitTxReq(output int cycles);
    cycles = 0;
    while (!tx_req && cycles < 100) begin
      stepCycle();
      cycles++;
    end
  endtask

  task automatic checkPayload(input string name, input logic [7:0] tag,
                              input string digits, input int len);
    checkOutput({name, "_payload"}, tx_string[103:0], makePayload(tag, digits));
    checkOutput({name, "_length"}, 104'(tx_length), 104'(len));
    checkOutput({name, "_upper_zero"}, 104'(|tx_string[1095:104]), 104'd0);
  endtask

  // Full frame: accept, latency, payload, then a busy window of 50 cycles.
  task automatic runFrame(input string name, input logic [31:0] value, input logic [7:0] tag,
                          input string digits, input int len);
    int cycles;
    int doneCnt;
    int errCnt;
    applyStimulus(value, tag);
    checkOutput({name, "_ready_low"}, 104'(fmt_ready), 104'd0);
    waitTxReq(cycles);
    checkOutput({name, "_latency"}, 104'(cycles), 104'd43);
    checkPayload(name, tag, digits, len);
    stepCycle();
    checkOutput({name, "_req_pulse"}, 104'(tx_req), 104'd0);
    stepCycle();
    tx_busy = 1'b1;
    doneCnt = 0;
    errCnt  = 0;
    repeat (50) begin
      stepCycle();
      doneCnt += int'(fmt_done);
      errCnt  += int'(fmt_err);
    end
    tx_busy = 1'b0;
    repeat (5) begin
      stepCycle();
      doneCnt += int'(fmt_done);
      errCnt  += int'(fmt_err);
    end
    checkOutput({name, "_done_count"}, 104'(doneCnt), 104'd1);
    checkOutput({name, "_err_count"}, 104'(errCnt), 104'd0);
    checkOutput({name, "_ready_after"}, 104'(fmt_ready), 104'd1);
    checkOutput({name, "_held"}, tx_string[103:0], makePayload(tag, digits));
  endtask

  initial begin
    int cycles;
    int doneCnt;
    int reqCnt;
    sys_rst_n = 1'b0;
    fmt_req   = 1'b0;
    fmt_value = '0;
    fmt_tag   = '0;
    tx_busy   = 1'b0;
    repeat (2) stepCycle();
    checkOutput("rst_string", 104'(|tx_string), 104'd0);
    checkOutput("rst_length", 104'(tx_length), 104'd0);
    checkOutput("rst_req", 104'(tx_req), 104'd0);
    checkOutput("rst_done", 104'(fmt_done), 104'd0);
    checkOutput("rst_err", 104'(fmt_err), 104'd0);
    checkOutput("rst_ready", 104'(fmt_ready), 104'd1);
    sys_rst_n = 1'b1;
    stepCycle();

    runFrame("zero", 32'd0, "V", "0", 3);
    runFrame("max", 32'hFFFF_FFFF, "V", "4294967295", 12);
    runFrame("embedded", 32'd1000, "F", "1000", 6);

    // Busy never rises: error pulse 16 cycles after tx_req, no done.
    applyStimulus(32'd42, "T");
    waitTxReq(cycles);
    checkOutput("timeout_latency", 104'(cycles), 104'd43);
    cycles  = 0;
    doneCnt = 0;
    while (!fmt_err && cycles < 40) begin
      stepCycle();
      cycles++;
      doneCnt += int'(fmt_done);
    end
    checkOutput("timeout_cycles", 104'(cycles), 104'd16);
    checkOutput("timeout_no_done", 104'(doneCnt), 104'd0);
    stepCycle();
    checkOutput("timeout_ready", 104'(fmt_ready), 104'd1);
    checkOutput("timeout_err_pulse", 104'(fmt_err), 104'd0);

    // Second request mid-conversion must be ignored.
    applyStimulus(32'd12345, "A");
    repeat (5) stepCycle();
    fmt_value = 32'd7;
    fmt_tag   = "B";
    fmt_req   = 1'b1;
    stepCycle();
    fmt_req   = 1'b0;
    waitTxReq(cycles);
    checkOutput("ignore_latency", 104'(cycles), 104'd37);
    checkPayload("ignore", "A", "12345", 7);
    tx_busy = 1'b1;
    repeat (3) stepCycle();
    tx_busy = 1'b0;
    repeat (3) stepCycle();
    checkOutput("ignore_ready", 104'(fmt_ready), 104'd1);

    // Reset mid-conversion aborts with no request or completion.
    applyStimulus(32'd555, "R");
    repeat (10) stepCycle();
    sys_rst_n = 1'b0;
    stepCycle();
    sys_rst_n = 1'b1;
    checkOutput("abort_string", 104'(|tx_string), 104'd0);
    checkOutput("abort_length", 104'(tx_length), 104'd0);
    checkOutput("abort_ready", 104'(fmt_ready), 104'd1);
    reqCnt  = 0;
    doneCnt = 0;
    repeat (60) begin
      stepCycle();
      reqCnt  += int'(tx_req);
      doneCnt += int'(fmt_done) + int'(fmt_err);
    end
    checkOutput("abort_no_req", 104'(reqCnt), 104'd0);
    checkOutput("abort_no_pulse", 104'(doneCnt), 104'd0);

`ifdef NUM_FMT_SIGNED_EN
    runFrame("neg_one", 32'hFFFF_FFFF, "V", "-1", 4);
    runFrame("neg_min", 32'h8000_0000, "V", "-2147483648", 13);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
